// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the datapath.
// slave = the controller, master = the datapath/IR side that consumes the strobes.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWre;
  logic [1:0]       PCSrc;
  logic             IRWre;
  logic             InsMemRW;
  logic             RegWre;
  logic             RegOut;
  logic             ALUM2Reg;
  logic             ALUSrcB;
  logic             ExtSel;
  logic [2:0]       ALUOp;
  logic             mRD;
  logic             mWR;
  logic             halted;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport slave (
    input  opcode, zero, mem_ready,
    output PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegOut, ALUM2Reg,
           ALUSrcB, ExtSel, ALUOp, mRD, mWR, halted, state, instr_count
  );

  modport master (
    output opcode, zero, mem_ready,
    input  PCWre, PCSrc, IRWre, InsMemRW, RegWre, RegOut, ALUM2Reg,
           ALUSrcB, ExtSel, ALUOp, mRD, mWR, halted, state, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EXE/MEM/WB sequencer for the MIPS-subset CPU.
// Only state and the retire counter are registered; every strobe decodes from state+opcode.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic            clk,
  input logic            reset,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_AL = 4'b0010,
    S_WB_AL  = 4'b0011,
    S_EXE_BR = 4'b0100,
    S_EXE_LS = 4'b0101,
    S_MEM    = 4'b0110,
    S_WB_LD  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b011000, OP_SW  = 6'b100110, OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000, OP_J   = 6'b111000, OP_HALT = 6'b111111;

  state_t           st, nxt;
  logic [CNT_W-1:0] cnt;

  logic       is_r, is_al, is_ls, is_lw, is_sw;
  logic [2:0] aluop_dec;
  logic       srcb_dec, ext_dec, dec_en;

  always_comb begin
    is_lw = (bus.opcode == OP_LW);
    is_sw = (bus.opcode == OP_SW);
    is_ls = is_lw | is_sw;
    is_r  = (bus.opcode == OP_ADD) | (bus.opcode == OP_SUB) | (bus.opcode == OP_OR) |
            (bus.opcode == OP_AND) | (bus.opcode == OP_SLT);
    is_al = is_r | (bus.opcode == OP_ADDI) | (bus.opcode == OP_ORI);
    case (bus.opcode)
      OP_SUB, OP_BEQ: aluop_dec = 3'b001;
      OP_OR,  OP_ORI: aluop_dec = 3'b011;
      OP_AND:         aluop_dec = 3'b100;
      OP_SLT:         aluop_dec = 3'b010;
      default:        aluop_dec = 3'b000;
    endcase
    srcb_dec = (bus.opcode == OP_ADDI) | (bus.opcode == OP_ORI) | is_ls;
    ext_dec  = (bus.opcode == OP_ADDI) | (bus.opcode == OP_BEQ) | is_ls;
  end

  // Datapath selects are only meaningful once the instruction is past decode.
  assign dec_en = (st != S_IF) && (st != S_ID) && (st != S_HALT);

  always_comb begin
    nxt          = st;
    bus.PCWre    = 1'b0;
    bus.PCSrc    = 2'b00;
    bus.IRWre    = 1'b0;
    bus.InsMemRW = 1'b0;
    bus.RegWre   = 1'b0;
    bus.RegOut   = 1'b0;
    bus.ALUM2Reg = 1'b0;
    bus.mRD      = 1'b0;
    bus.mWR      = 1'b0;
    bus.halted   = 1'b0;
    case (st)
      S_IF: begin
        bus.IRWre    = 1'b1;
        bus.InsMemRW = 1'b1;
        nxt          = S_ID;
      end
      S_ID: begin
        if (is_al)                        nxt = S_EXE_AL;
        else if (bus.opcode == OP_BEQ)    nxt = S_EXE_BR;
        else if (is_ls)                   nxt = S_EXE_LS;
        else if (bus.opcode == OP_HALT)   nxt = S_HALT;
        else begin
          // J and unknown opcodes retire straight out of decode.
          bus.PCWre = 1'b1;
          bus.PCSrc = (bus.opcode == OP_J) ? 2'b11 : 2'b00;
          nxt       = S_IF;
        end
      end
      S_EXE_AL: nxt = S_WB_AL;
      S_WB_AL: begin
        bus.RegWre = 1'b1;
        bus.RegOut = is_r;
        bus.PCWre  = 1'b1;
        nxt        = S_IF;
      end
      S_EXE_BR: begin
        bus.PCWre = 1'b1;
        bus.PCSrc = bus.zero ? 2'b01 : 2'b00;
        nxt       = S_IF;
      end
      S_EXE_LS: nxt = S_MEM;
      S_MEM: begin
        bus.mRD = is_lw;
        bus.mWR = is_sw;
        if (bus.mem_ready) begin
          if (is_lw) nxt = S_WB_LD;
          else begin
            bus.PCWre = 1'b1;
            nxt       = S_IF;
          end
        end
      end
      S_WB_LD: begin
        bus.RegWre   = 1'b1;
        bus.ALUM2Reg = 1'b1;
        bus.PCWre    = 1'b1;
        nxt          = S_IF;
      end
      S_HALT: bus.halted = 1'b1;
      default: nxt = S_IF;
    endcase
  end

  assign bus.ALUOp       = dec_en ? aluop_dec : 3'b000;
  assign bus.ALUSrcB     = dec_en & srcb_dec;
  assign bus.ExtSel      = dec_en & ext_dec;
  assign bus.state       = st;
  assign bus.instr_count = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= S_IF;
      cnt <= '0;
    end else begin
      st <= nxt;
      if (bus.PCWre) cnt <= cnt + 1'b1;
    end
  end

endmodule
